// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with a runtime-loadable pattern.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               dout,
    output logic               dout_q,
    output logic [COUNT_W-1:0] match_cnt
);

    localparam int                FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] window;
    logic               shiftEn;

    assign shiftEn = din_valid & ~pat_load;
    assign window  = {hist_q, din};
    assign dout    = shiftEn && (fill_q == FILL_MAX) && (window == pat_q);

    // fill doubles as the state: it counts how many history bits are trustworthy.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (din_valid) begin
            if (!OVERLAP && dout) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_LEN-2:0];
                fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            dout_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            dout_q <= dout;
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [COUNT_W-1:0] cnt_q;

    // Saturates at all-ones instead of wrapping; pattern reloads leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (dout && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: four configurations share one stimulus stream,
// each checked against a behavioural model through a scoreboard queue.
module tb_seq_detect_param;

    typedef struct packed {
        logic       dq;
        logic [7:0] cnt;
    } expEntry_t;

    logic        clk;
    logic        rst;
    logic        din;
    logic        dinValid;
    logic        patLoad;
    logic [15:0] patIn;

    logic        doutW  [4];
    logic        doutQW [4];
    logic [7:0]  cntW   [4];
    logic [1:0]  cntSmall;

    int checkCount;
    int errorCount;

    expEntry_t sbQueue[$];

    // Model configuration per instance: length, overlap, counter ceiling, reset pattern.
    int          mLen  [4] = '{4, 3, 3, 2};
    bit          mOvl  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          mCmax [4] = '{255, 255, 255, 3};
    logic [15:0] mRstP [4] = '{16'hB, 16'h5, 16'h5, 16'h3};

    logic [15:0] mHist [4];
    logic [15:0] mPat  [4];
    int          mFill [4];
    int          mCnt  [4];
    logic        expD  [4];

    seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) dutA (
        .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .pat_load(patLoad),
        .pat_in(patIn[3:0]), .dout(doutW[0]), .dout_q(doutQW[0]), .match_cnt(cntW[0]));

    seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .COUNT_W(8)) dutB (
        .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .pat_load(patLoad),
        .pat_in(patIn[2:0]), .dout(doutW[1]), .dout_q(doutQW[1]), .match_cnt(cntW[1]));

    seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .COUNT_W(8)) dutD (
        .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .pat_load(patLoad),
        .pat_in(patIn[2:0]), .dout(doutW[2]), .dout_q(doutQW[2]), .match_cnt(cntW[2]));

    seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .COUNT_W(2)) dutC (
        .clk(clk), .rst(rst), .din(din), .din_valid(dinValid), .pat_load(patLoad),
        .pat_in(patIn[1:0]), .dout(doutW[3]), .dout_q(doutQW[3]), .match_cnt(cntSmall));

    assign cntW[3] = {6'b0, cntSmall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] patMask(input int i);
        return 16'((32'd1 << mLen[i]) - 1);
    endfunction

    function automatic logic modelDout(input int i);
        logic [15:0] win;
        win = ((mHist[i] << 1) | {15'b0, din}) & patMask(i);
        return dinValid && !patLoad && (mFill[i] == mLen[i] - 1) && (win == mPat[i]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mHist[i] = '0;
            mFill[i] = 0;
            mPat[i]  = mRstP[i];
            mCnt[i]  = 0;
        end
    endtask

    task automatic modelStep(input int i, input logic matched);
        logic [15:0] win;
        win = ((mHist[i] << 1) | {15'b0, din}) & patMask(i);
        if (patLoad) begin
            mPat[i]  = patIn & patMask(i);
            mHist[i] = '0;
            mFill[i] = 0;
        end else if (dinValid) begin
            if (!mOvl[i] && matched) begin
                mHist[i] = '0;
                mFill[i] = 0;
            end else begin
                mHist[i] = win & (patMask(i) >> 1);
                mFill[i] = (mFill[i] + 1 > mLen[i] - 1) ? mLen[i] - 1 : mFill[i] + 1;
            end
        end
`ifdef SEQ_DET_CNT_EN
        if (matched && mCnt[i] < mCmax[i]) mCnt[i]++;
`endif
    endtask

    // One clock of stimulus: Mealy output checked before the edge, registered outputs after.
    task automatic applyStimulus(input logic v, input logic d, input logic ld, input logic [15:0] p);
        expEntry_t e;
        @(negedge clk);
        dinValid = v;
        din      = d;
        patLoad  = ld;
        patIn    = p;
        #1;
        for (int i = 0; i < 4; i++) begin
            expD[i] = modelDout(i);
            checkOutput($sformatf("dout[%0d]", i), {31'b0, doutW[i]}, {31'b0, expD[i]});
        end
        for (int i = 0; i < 4; i++) begin
            modelStep(i, expD[i]);
            e.dq  = expD[i];
            e.cnt = 8'(mCnt[i]);
            sbQueue.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sbQueue.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sbQueue.pop_front();
                checkOutput($sformatf("dout_q[%0d]", i), {31'b0, doutQW[i]}, {31'b0, e.dq});
                checkOutput($sformatf("match_cnt[%0d]", i), {24'b0, cntW[i]}, {24'b0, e.cnt});
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_dout[%0d]", tag, i), {31'b0, doutW[i]}, 32'd0);
            checkOutput($sformatf("%s_dout_q[%0d]", tag, i), {31'b0, doutQW[i]}, 32'd0);
            checkOutput($sformatf("%s_cnt[%0d]", tag, i), {24'b0, cntW[i]}, 32'd0);
        end
    endtask

    // Reset held for one cycle with a valid '1' on din to show it cannot leak through.
    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        dinValid = 1'b1;
        din      = 1'b1;
        patLoad  = 1'b0;
        #1;
        modelReset();
        sbQueue.delete();
        checkAllZero("rst_async");
        @(posedge clk);
        #1;
        checkAllZero("rst_hold");
        @(negedge clk);
        rst      = 1'b0;
        dinValid = 1'b0;
    endtask

    task automatic sendBits(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) applyStimulus(1'b1, bits[k], 1'b0, 16'h0);
    endtask

    function automatic int expCount(input int n);
`ifdef SEQ_DET_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst      = 1'b0;
        din      = 1'b0;
        dinValid = 1'b0;
        patLoad  = 1'b0;
        patIn    = '0;
        modelReset();

        doReset();
        sendBits(16'b1011011, 7);
        checkOutput("cnt_A_1011011", {24'b0, cntW[0]}, 32'(expCount(2)));

        doReset();
        sendBits(16'b10101, 5);
        checkOutput("cnt_B_nonoverlap", {24'b0, cntW[1]}, 32'(expCount(1)));
        checkOutput("cnt_D_overlap", {24'b0, cntW[2]}, 32'(expCount(2)));

        applyStimulus(1'b1, 1'b1, 1'b1, 16'b0110);
        sendBits(16'b0110, 4);

        applyStimulus(1'b0, 1'b0, 1'b1, 16'b1011);
        sendBits(16'b10, 2);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, k[0], 1'b0, 16'h0);
        sendBits(16'b11, 2);

        doReset();
        sendBits(16'b101, 3);
        doReset();
        sendBits(16'b1, 1);

        doReset();
        sendBits(16'b111111, 6);
        checkOutput("cnt_C_saturate", {24'b0, cntW[3]}, 32'(expCount(3)));

        for (int k = 0; k < 80; k++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
